// File: rtl/xc_malu_seq.sv
// Sequencer for the multi-cycle multiply/divide datapath: latches one operation,
// steps the iteration registers from the datapath each cycle, and holds the result until consumed.
module xc_malu_seq #(
    parameter int MAX_CYCLES = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [9:0]  req_op,
    input  logic [4:0]  req_pw,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [31:0] req_rs3,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_result,
    output logic        rsp_error,
    output logic        busy,
    output logic [31:0] dp_rs1,
    output logic [31:0] dp_rs2,
    output logic [31:0] dp_rs3,
    output logic [9:0]  dp_op,
    output logic [4:0]  dp_pw,
    output logic        dp_valid,
    output logic        dp_flush,
    output logic [5:0]  dp_count,
    output logic [63:0] dp_acc,
    output logic [31:0] dp_arg_0,
    output logic [31:0] dp_arg_1,
    input  logic [63:0] dp_n_acc,
    input  logic [31:0] dp_n_arg_0,
    input  logic [31:0] dp_n_arg_1,
    input  logic        dp_ready,
    input  logic [63:0] dp_result
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_t;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // rsp_valid, rsp_result and rsp_error stay stable until that transfer.
    state_t      state, state_nxt;
    logic [9:0]  op_q;
    logic [4:0]  pw_q;
    logic [31:0] rs1_q, rs2_q, rs3_q;
    logic [5:0]  count_q;
    logic [63:0] acc_q;
    logic [31:0] arg_0_q, arg_1_q;
    logic [63:0] result_q;
    logic        error_q;
    logic        dp_flush_q;

    logic accept, op_legal, watchdog;

    assign accept   = req_valid && req_ready;
    assign op_legal = (req_op != '0) && ((req_op & (req_op - 10'd1)) == '0);
    assign watchdog = (count_q == 6'(MAX_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = op_legal ? S_RUN : S_RESP;
            S_RUN:  if (dp_ready || watchdog) state_nxt = S_RESP;
            S_RESP: if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q <= '0; pw_q <= '0;
            rs1_q <= '0; rs2_q <= '0; rs3_q <= '0;
            count_q <= '0; acc_q <= '0; arg_0_q <= '0; arg_1_q <= '0;
            result_q <= '0; error_q <= 1'b0;
            dp_flush_q <= 1'b1;
        end else begin
            dp_flush_q <= flush;
            if (flush) begin
                count_q <= '0; acc_q <= '0; arg_0_q <= '0; arg_1_q <= '0;
                result_q <= '0; error_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (accept) begin
                        op_q <= req_op; pw_q <= req_pw;
                        rs1_q <= req_rs1; rs2_q <= req_rs2; rs3_q <= req_rs3;
                        count_q <= '0; acc_q <= '0; arg_0_q <= req_rs1; arg_1_q <= '0;
                        result_q <= '0;
                        error_q <= !op_legal;
                    end
                    S_RUN: begin
                        // Completion and watchdog both freeze the iteration registers.
                        if (dp_ready) begin
                            result_q <= dp_result;
                            error_q  <= 1'b0;
                        end else if (watchdog) begin
                            result_q <= '0;
                            error_q  <= 1'b1;
                        end else begin
                            acc_q   <= dp_n_acc;
                            arg_0_q <= dp_n_arg_0;
                            arg_1_q <= dp_n_arg_1;
                            count_q <= count_q + 6'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign req_ready  = (state == S_IDLE) && !flush;
    assign rsp_valid  = (state == S_RESP);
    assign rsp_result = result_q;
    assign rsp_error  = error_q;
    assign busy       = (state != S_IDLE);
    assign dp_valid   = (state == S_RUN);
    assign dp_op      = (state == S_RUN) ? op_q : '0;
    assign dp_pw      = pw_q;
    assign dp_rs1     = rs1_q;
    assign dp_rs2     = rs2_q;
    assign dp_rs3     = rs3_q;
    assign dp_flush   = dp_flush_q;
    assign dp_count   = count_q;
    assign dp_acc     = acc_q;
    assign dp_arg_0   = arg_0_q;
    assign dp_arg_1   = arg_1_q;

endmodule

// File: tb/tb_xc_malu_seq.sv
// Bench for xc_malu_seq: the bench plays the datapath with simple arithmetic stepping
// and checks latency, result passing, watchdog, flush and reset behaviour.
module tb_xc_malu_seq;

    logic        clock = 1'b0;
    logic        reset, req_valid, req_ready, flush, rsp_valid, rsp_ready, rsp_error, busy;
    logic [9:0]  req_op, dp_op;
    logic [4:0]  req_pw, dp_pw;
    logic [31:0] req_rs1, req_rs2, req_rs3, dp_rs1, dp_rs2, dp_rs3;
    logic [63:0] rsp_result, dp_acc, dp_n_acc, dp_result;
    logic        dp_valid, dp_flush, dp_ready;
    logic [5:0]  dp_count;
    logic [31:0] dp_arg_0, dp_arg_1, dp_n_arg_0, dp_n_arg_1;

    logic [63:0] inc;
    int n_checks = 0;
    int n_pass = 0;

    xc_malu_seq #(.MAX_CYCLES(40)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_pw(req_pw), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
        .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_error(rsp_error), .busy(busy), .dp_rs1(dp_rs1), .dp_rs2(dp_rs2), .dp_rs3(dp_rs3),
        .dp_op(dp_op), .dp_pw(dp_pw), .dp_valid(dp_valid), .dp_flush(dp_flush),
        .dp_count(dp_count), .dp_acc(dp_acc), .dp_arg_0(dp_arg_0), .dp_arg_1(dp_arg_1),
        .dp_n_acc(dp_n_acc), .dp_n_arg_0(dp_n_arg_0), .dp_n_arg_1(dp_n_arg_1),
        .dp_ready(dp_ready), .dp_result(dp_result)
    );

    always #5 clock = ~clock;

    // Datapath stand-in: each step adds a fixed increment to acc and fixed offsets to the args.
    assign dp_n_acc   = dp_acc + inc;
    assign dp_n_arg_0 = dp_arg_0 + 32'd1;
    assign dp_n_arg_1 = dp_arg_1 + 32'd3;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] ref_result(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q;
        logic [31:0] u;
        sa = a; sb = b;
        case (op)
            10'h001: begin q = sa / sb; return {{32{q[31]}}, q}; end
            10'h002: begin u = a / b;   return {32'd0, u}; end
            10'h004: begin q = sa % sb; return {{32{q[31]}}, q}; end
            10'h008: begin u = a % b;   return {32'd0, u}; end
            10'h010: return 64'(longint'(sa) * longint'(sb));
            10'h020: return 64'(a) * 64'(b);
            10'h040: return 64'(longint'(sa) * longint'({32'd0, b}));
            default: return 64'd0;
        endcase
    endfunction

    // Issues one op, plays the datapath, holds rsp_ready low for 'hold' cycles, then consumes.
    // n_ready = number of RUN cycles before completion (0 = never completes).
    task automatic drive_op(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int n_ready, input int hold, input logic [63:0] res_val,
                            output int lat, output int bad, output logic [63:0] got_res,
                            output logic got_err, output logic saw_dp, output int last_count);
        int cycles;
        bit legal;
        legal = ($countones(op) == 1);
        inc = {32'($urandom), 32'($urandom)} | 64'd1;
        bad = 0; saw_dp = 1'b0; last_count = 0;
        req_valid = 1'b1; req_op = op; req_pw = 5'($urandom_range(0, 31));
        req_rs1 = a; req_rs2 = b; req_rs3 = $urandom;
        #2;
        if (!req_ready) bad++;
        step();
        req_valid = 1'b0;
        cycles = 1;
        while (!rsp_valid && cycles < 200) begin
            dp_ready  = (n_ready != 0) && (cycles == n_ready);
            dp_result = dp_ready ? res_val : {32'($urandom), 32'($urandom)};
            #2;
            saw_dp = saw_dp | dp_valid;
            if (dp_valid !== legal || req_ready !== 1'b0 || busy !== 1'b1) bad++;
            if (int'(dp_count) != cycles - 1) bad++;
            if (dp_acc !== 64'(cycles - 1) * inc) bad++;
            if (dp_arg_0 !== a + 32'(cycles - 1) || dp_arg_1 !== 32'(3 * (cycles - 1))) bad++;
            if (dp_op !== op || dp_rs1 !== a || dp_rs2 !== b) bad++;
            last_count = int'(dp_count);
            step();
            cycles++;
        end
        dp_ready = 1'b0;
        lat = cycles;
        got_res = rsp_result; got_err = rsp_error;
        for (int i = 0; i < hold; i++) begin
            dp_result = {32'($urandom), 32'($urandom)};
            rsp_ready = 1'b0;
            #2;
            if (rsp_valid !== 1'b1 || rsp_result !== got_res || rsp_error !== got_err) bad++;
            if (req_ready !== 1'b0 || dp_op !== 10'd0) bad++;
            step();
        end
        rsp_ready = 1'b1;
        #2;
        if (rsp_valid !== 1'b1 || req_ready !== 1'b0) bad++;
        step();
        rsp_ready = 1'b0;
        #2;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) bad++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        #2;
        n_checks++; if (dp_flush !== 1'b1) $display("FAIL reset_dp_flush got %0b exp 1", dp_flush); else n_pass++;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %0b exp 1", req_ready); else n_pass++;
        n_checks++; if ({rsp_valid, busy, dp_valid, rsp_error} !== 4'b0) $display("FAIL reset_flags got %b exp 0000", {rsp_valid, busy, dp_valid, rsp_error}); else n_pass++;
        n_checks++; if ({dp_op, dp_count, dp_acc, dp_arg_0, dp_arg_1, rsp_result} !== '0) $display("FAIL reset_regs got nonzero exp 0"); else n_pass++;
        step();
        #2;
        n_checks++; if (dp_flush !== 1'b0) $display("FAIL reset_dp_flush_clear got %0b exp 0", dp_flush); else n_pass++;
    endtask

    task automatic test_mulu();
        int lat, bad, lc; logic [63:0] r; logic e, sd;
        drive_op(10'h020, 32'hFFFFFFFF, 32'd2, 32, 0, ref_result(10'h020, 32'hFFFFFFFF, 32'd2), lat, bad, r, e, sd, lc);
        n_checks++; if (lat !== 33) $display("FAIL mulu_latency got %0d exp 33", lat); else n_pass++;
        n_checks++; if (r !== 64'h1_FFFFFFFE) $display("FAIL mulu_result got %h exp 1fffffffe", r); else n_pass++;
        n_checks++; if (e !== 1'b0) $display("FAIL mulu_error got %0b exp 0", e); else n_pass++;
        n_checks++; if (lc !== 31) $display("FAIL mulu_last_count got %0d exp 31", lc); else n_pass++;
        n_checks++; if (bad !== 0) $display("FAIL mulu_steps got %0d bad cycles exp 0", bad); else n_pass++;
    endtask

    task automatic test_div_hold();
        int lat, bad, lc; logic [63:0] r; logic e, sd;
        drive_op(10'h001, 32'hFFFFFFF9, 32'd2, 6, 5, ref_result(10'h001, 32'hFFFFFFF9, 32'd2), lat, bad, r, e, sd, lc);
        n_checks++; if (r !== 64'hFFFFFFFF_FFFFFFFD) $display("FAIL div_result got %h exp fffffffffffffffd", r); else n_pass++;
        n_checks++; if (lat !== 7) $display("FAIL div_latency got %0d exp 7", lat); else n_pass++;
        n_checks++; if (bad !== 0) $display("FAIL div_hold got %0d bad cycles exp 0", bad); else n_pass++;
    endtask

    task automatic test_illegal();
        int lat, bad, lc; logic [63:0] r; logic e, sd;
        logic [9:0] ops [2];
        ops[0] = 10'h003; ops[1] = 10'h000;
        for (int i = 0; i < 2; i++) begin
            drive_op(ops[i], $urandom, $urandom, 5, 1, 64'hDEAD_BEEF_0000_1111, lat, bad, r, e, sd, lc);
            n_checks++; if (lat !== 1) $display("FAIL illegal_latency op=%h got %0d exp 1", ops[i], lat); else n_pass++;
            n_checks++; if (e !== 1'b1 || r !== 64'd0) $display("FAIL illegal_rsp op=%h got err=%0b res=%h exp err=1 res=0", ops[i], e, r); else n_pass++;
            n_checks++; if (sd !== 1'b0 || bad !== 0) $display("FAIL illegal_dp op=%h got dp_valid_seen=%0b bad=%0d exp 0/0", ops[i], sd, bad); else n_pass++;
        end
    endtask

    task automatic test_watchdog();
        int lat, bad, lc; logic [63:0] r; logic e, sd;
        drive_op(10'h020, $urandom, $urandom, 0, 2, 64'd0, lat, bad, r, e, sd, lc);
        n_checks++; if (lat !== 41) $display("FAIL watchdog_latency got %0d exp 41", lat); else n_pass++;
        n_checks++; if (e !== 1'b1 || r !== 64'd0) $display("FAIL watchdog_rsp got err=%0b res=%h exp err=1 res=0", e, r); else n_pass++;
        n_checks++; if (lc !== 39) $display("FAIL watchdog_count got %0d exp 39", lc); else n_pass++;
        n_checks++; if (bad !== 0) $display("FAIL watchdog_steps got %0d bad cycles exp 0", bad); else n_pass++;
    endtask

    task automatic test_flush();
        int lat, bad, lc; logic [63:0] r; logic e, sd;
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        inc = 64'h1234_5678_9ABC_DEF1;
        req_valid = 1'b1; req_op = 10'h020; req_rs1 = a; req_rs2 = b; req_rs3 = 32'd0;
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            dp_ready = 1'b0;
            step();
        end
        flush = 1'b1; req_valid = 1'b1; req_op = 10'h001;
        #2;
        n_checks++; if (req_ready !== 1'b0 || dp_valid !== 1'b1) $display("FAIL flush_cycle got req_ready=%0b dp_valid=%0b exp 0/1", req_ready, dp_valid); else n_pass++;
        step();
        flush = 1'b0; req_valid = 1'b0;
        #2;
        n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL flush_idle got busy=%0b rsp_valid=%0b exp 0/0", busy, rsp_valid); else n_pass++;
        n_checks++; if (dp_flush !== 1'b1) $display("FAIL flush_dp_flush got %0b exp 1", dp_flush); else n_pass++;
        n_checks++; if (dp_acc !== 64'd0 || dp_count !== 6'd0 || dp_arg_0 !== 32'd0 || dp_arg_1 !== 32'd0) $display("FAIL flush_regs got acc=%h count=%0d exp 0/0", dp_acc, dp_count); else n_pass++;
        step();
        #2;
        n_checks++; if (busy !== 1'b0 || dp_flush !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL flush_no_accept got busy=%0b dp_flush=%0b rsp_valid=%0b exp 0/0/0", busy, dp_flush, rsp_valid); else n_pass++;
        drive_op(10'h020, a, b, 12, 1, ref_result(10'h020, a, b), lat, bad, r, e, sd, lc);
        n_checks++; if (r !== 64'(a) * 64'(b) || e !== 1'b0 || lat !== 13 || bad !== 0) $display("FAIL flush_reissue got res=%h lat=%0d bad=%0d exp res=%h lat=13 bad=0", r, lat, bad, 64'(a) * 64'(b)); else n_pass++;
    endtask

    task automatic test_reset_resp();
        req_valid = 1'b1; req_op = 10'h003;
        step();
        req_valid = 1'b0;
        #2;
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL rstresp_pre got rsp_valid=%0b exp 1", rsp_valid); else n_pass++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #2;
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rstresp_post got v=%0b rdy=%0b busy=%0b exp 0/1/0", rsp_valid, req_ready, busy); else n_pass++;
        n_checks++; if (dp_flush !== 1'b1 || rsp_error !== 1'b0) $display("FAIL rstresp_flush got dp_flush=%0b err=%0b exp 1/0", dp_flush, rsp_error); else n_pass++;
    endtask

    task automatic test_random();
        int lat, bad, lc, n, hold; logic [63:0] r, exp_r; logic e, sd;
        logic [31:0] a, b;
        logic [9:0] op;
        for (int i = 0; i < 25; i++) begin
            op = 10'd1 << $urandom_range(0, 6);
            a = $urandom; b = $urandom | 32'd1;
            if (b == 32'hFFFFFFFF) b = 32'd3;
            n = $urandom_range(1, 40);
            hold = $urandom_range(0, 3);
            exp_r = ref_result(op, a, b);
            drive_op(op, a, b, n, hold, exp_r, lat, bad, r, e, sd, lc);
            n_checks++; if (r !== exp_r || e !== 1'b0) $display("FAIL rand_result op=%h got %h err=%0b exp %h err=0", op, r, e, exp_r); else n_pass++;
            n_checks++; if (lat !== n + 1 || bad !== 0) $display("FAIL rand_timing op=%h got lat=%0d bad=%0d exp lat=%0d bad=0", op, lat, bad, n + 1); else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_pw = '0;
        req_rs1 = '0; req_rs2 = '0; req_rs3 = '0; flush = 1'b0; rsp_ready = 1'b0;
        dp_ready = 1'b0; dp_result = '0; inc = 64'd1;
        test_reset();
        test_mulu();
        test_div_hold();
        test_illegal();
        test_watchdog();
        test_flush();
        test_reset_resp();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/xc_malu_seq.md
Name: xc_malu_seq

Overview:
Sequencer for the multi-cycle multiply/divide/remainder/packed-multiply datapath. Accepts one operation at a time from the issuing pipeline stage and latches the operands and opcode. Owns the iteration state registers (count, acc, arg_0, arg_1), steps them from the datapath's next-state outputs each cycle, and returns the 64-bit result over a held valid/ready response handshake. Also handles flush, illegal opcodes and a cycle watchdog.

Parameters:
MAX_CYCLES, 40, watchdog limit on iterations per operation (legal range 1..63).

Ports:
clock  in  1  Single clock; all state updates on the rising edge.
reset  in  1  Synchronous, active-high reset.
req_valid  in  1  Request valid.
req_ready  out  1  Request accepted when req_valid && req_ready.
req_op  in  10  One-hot opcode: {pclmul,pmul,clmul,mulsu,mulu,mul,remu,rem,divu,div}, bit 0 = div.
req_pw  in  5  One-hot packed width: {pw_2,pw_4,pw_8,pw_16,pw_32}.
req_rs1 / req_rs2 / req_rs3  in  32 each  Source operands.
flush  in  1  Abort the current operation.
rsp_valid  out  1  Result valid.
rsp_ready  in  1  Consumer accepts the result.
rsp_result  out  64  Result.
rsp_error  out  1  Operation aborted: illegal opcode or watchdog expiry.
busy  out  1  High in any state other than IDLE.
dp_rs1 / dp_rs2 / dp_rs3  out  32 each  Latched operands.
dp_op  out  10  Latched opcode. All zero outside RUN.
dp_pw  out  5  Latched packed width.
dp_valid  out  1  High in RUN.
dp_flush  out  1  Registered copy of flush | reset.
dp_count  out  6  Count register.
dp_acc  out  64  Accumulator register.
dp_arg_0 / dp_arg_1  out  32 each  Argument registers.
dp_n_acc  in  64  Next accumulator value from the datapath.
dp_n_arg_0 / dp_n_arg_1  in  32 each  Next argument values from the datapath.
dp_ready  in  1  Datapath reports the operation complete.
dp_result  in  64  Datapath result.

Behaviour:
- Reset: state=IDLE. All outputs and registers are 0, except req_ready=1. dp_flush=1 in the cycle after reset.
- States: IDLE, RUN, RESP.
- IDLE: req_ready=1.
  - On accept, latch req_op, req_pw and the three operands.
  - Load count=0, acc=0, arg_0=req_rs1, arg_1=0.
  - If req_op is one-hot, go to RUN.
  - Otherwise (zero bits or more than one bit set): go to RESP with rsp_error=1 and rsp_result=0. The datapath is never started.
  - req_pw is not checked.
- RUN: dp_valid=1; req_ready=0.
  - Each cycle with dp_ready=0: acc<=dp_n_acc, arg_0<=dp_n_arg_0, arg_1<=dp_n_arg_1, count<=count+1.
  - dp_ready=1: capture dp_result into rsp_result, set rsp_error=0, go to RESP. Registers are not updated that cycle.
  - Watchdog: if count==MAX_CYCLES-1 and dp_ready=0, go to RESP with rsp_error=1 and rsp_result=0.
  - count never wraps.
- RESP: rsp_valid=1. rsp_result and rsp_error are held stable until rsp_valid && rsp_ready.
  - On handshake, go to IDLE. A new request is not accepted in the same cycle, so minimum issue spacing is RUN length + 2 cycles.
- Latency: request accept to rsp_valid = N+1 cycles, where N = number of RUN cycles up to and including the dp_ready cycle.
- flush, in any state, has priority over all other events:
  - Next state is IDLE and rsp_valid is cleared. A pending response is discarded.
  - count, acc, arg_0 and arg_1 are zeroed. dp_flush=1 in the following cycle.
  - A req_valid in the flush cycle is not accepted (req_ready is forced to 0 while flush=1).
- reset mid-operation behaves identically to flush.
- dp_op is forced to 0 outside RUN, so no datapath route is active while idle.

Test Plan:
1. mulu, rs1=0xFFFFFFFF, rs2=2; model asserts dp_ready after 32 RUN cycles -> rsp_valid 33 cycles after accept; rsp_result=0x1_FFFFFFFE; rsp_error=0; dp_count=31 on the last step.
2. div, rs1=-7, rs2=2; rsp_ready held low for 5 cycles -> rsp_result=0xFFFFFFFF_FFFFFFFD, stable and valid throughout; req_ready=0 until the handshake cycle +1.
3. req_op=0x003 (two bits set) -> RESP in the next cycle, rsp_error=1, rsp_result=0, dp_valid never asserted.
4. Model never asserts dp_ready, MAX_CYCLES=40 -> rsp_error=1 exactly 41 cycles after accept; dp_count=39 at expiry.
5. flush at RUN cycle 10 together with a new req_valid -> the request is not accepted; next cycle state=IDLE, dp_flush=1, dp_acc=0, no rsp_valid. Re-issue the op -> correct result.
6. reset asserted in RESP with rsp_valid=1 -> next cycle rsp_valid=0, req_ready=1, busy=0.
